// File: rtl/ascon_pkg.sv
// Shared types and constants for the ASCON pad I/O slice.
// Nibble-wide pad map: data [3:0], strb 4, last 5, idle 6.
package ascon_pkg;

    localparam int ASCON_WORD_W = 64;
    localparam int PAD_NIB_W    = 4;
    localparam int PAD_CNT      = 7;

    localparam int PAD_DATA_LSB = 0;
    localparam int PAD_STRB_BIT = 4;
    localparam int PAD_LAST_BIT = 5;
    localparam int PAD_IDLE_BIT = 6;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STRB,
        WAIT_LOW
    } tx_state_e;

endpackage

// File: rtl/ascon_sync.sv
// N-flop synchronizer for asynchronous pad inputs.
// Flops clear to 0 under the synchronous active-low reset.
module ascon_sync #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [N-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[N-2:0], d};
        end
    end

    assign q = sync_q[N-1];

endmodule

// File: rtl/ascon_io_tx.sv
// Pad transmitter: streams 64-bit core results as MSB-first nibbles
// over a four-phase strobe/ack handshake with an asynchronous host.
module ascon_io_tx
    import ascon_pkg::*;
#(
    parameter int WORD_W      = ASCON_WORD_W,
    parameter int NIB_W       = PAD_NIB_W,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    input  logic [WORD_W-1:0] s_data_i,
    input  logic              s_valid_i,
    input  logic              s_last_i,
    output logic              s_ready_o,
    input  logic              pad_ack_i,
    output logic [NIB_W-1:0]  pad_data_o,
    output logic              pad_strb_o,
    output logic              pad_last_o,
    output logic              pad_idle_o,
    output logic [PAD_CNT-1:0] pad_oeb_o,
    output logic              err_o,
    input  logic              err_clr_i
);

    localparam int NIBS    = WORD_W / NIB_W;
    localparam int CNT_W   = (NIBS > 1) ? $clog2(NIBS) : 1;
    localparam int PH_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int TO_LAST = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIBS - 1);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(TO_LAST);

    tx_state_e         state_q, state_d;
    logic [WORD_W-1:0] shreg_q;
    logic              last_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [PH_W-1:0]   ph_q;
    logic              err_q;
    logic              live_q;
    logic              ack_s;
    logic              take;
    logic              advance;
    logic              timeout;
    logic              final_nib;

    ascon_sync #(
        .N(SYNC_STAGES)
    ) u_ack_sync (
        .clk  (wb_clk_i),
        .rst_n(wb_rst_ni),
        .d    (pad_ack_i),
        .q    (ack_s)
    );

    // live_q holds ready and pad drivers off for the reset cycles
    assign s_ready_o = live_q && (state_q == IDLE);
    assign take      = s_valid_i && s_ready_o;
    assign final_nib = (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        advance = 1'b0;
        timeout = 1'b0;
        if (TIMEOUT_CYC > 0 && state_q != IDLE && ph_q == PH_LAST) begin
            state_d = IDLE;
            timeout = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (take) state_d = SETUP;
                end
                SETUP: begin
                    if (!ack_s) state_d = STRB;
                end
                STRB: begin
                    if (ack_s) state_d = WAIT_LOW;
                end
                WAIT_LOW: begin
                    if (!ack_s) begin
                        advance = 1'b1;
                        state_d = final_nib ? IDLE : SETUP;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state_q <= IDLE;
            shreg_q <= '0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
            ph_q    <= '0;
            err_q   <= 1'b0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            live_q  <= 1'b1;

            if (state_d != state_q || state_q == IDLE) begin
                ph_q <= '0;
            end else begin
                ph_q <= ph_q + PH_W'(1);
            end

            if (timeout) begin
                err_q <= 1'b1;
            end else if (err_clr_i) begin
                err_q <= 1'b0;
            end

            if (timeout) begin
                shreg_q <= '0;
                last_q  <= 1'b0;
                cnt_q   <= '0;
            end else if (take) begin
                shreg_q <= s_data_i;
                last_q  <= s_last_i;
                cnt_q   <= '0;
            end else if (advance && !final_nib) begin
                shreg_q <= shreg_q << NIB_W;
                cnt_q   <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign pad_data_o = (state_q == IDLE) ? '0 : shreg_q[WORD_W-1 -: NIB_W];
    assign pad_strb_o = (state_q == STRB);
    assign pad_last_o = (state_q == STRB) && last_q && final_nib;
    assign pad_idle_o = (state_q == IDLE);
    assign pad_oeb_o  = live_q ? '0 : '1;
    assign err_o      = err_q;

endmodule

// File: tb/tb_ascon_io_tx.sv
// Directed bench for ascon_io_tx: vector table plus handshake corner cases.
// Host model acks each strobe three cycles after it rises.
module tb_ascon_io_tx;

    logic        clk;
    logic        rst_n;
    logic [63:0] s_data;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;
    logic        pad_ack;
    logic [3:0]  pad_data;
    logic        pad_strb;
    logic        pad_last;
    logic        pad_idle;
    logic [6:0]  pad_oeb;
    logic        err;
    logic        err_clr;

    int total = 0;
    int bad   = 0;

    logic [3:0] rx_nib[$];
    logic       rx_last[$];

    typedef struct {
        logic [63:0] data;
        logic        last;
    } vec_t;

    vec_t vecs[5];

    ascon_io_tx #(
        .TIMEOUT_CYC(16)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .s_data_i  (s_data),
        .s_valid_i (s_valid),
        .s_last_i  (s_last),
        .s_ready_o (s_ready),
        .pad_ack_i (pad_ack),
        .pad_data_o(pad_data),
        .pad_strb_o(pad_strb),
        .pad_last_o(pad_last),
        .pad_idle_o(pad_idle),
        .pad_oeb_o (pad_oeb),
        .err_o     (err),
        .err_clr_i (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [63:0] d, input logic l);
        int w;
        s_data  = d;
        s_last  = l;
        s_valid = 1'b1;
        w = 0;
        while (!s_ready && w < 500) begin
            @(negedge clk);
            w++;
        end
        if (!s_ready) chk("send_ready_wait", 0, 1);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic recv(input int n);
        int w;
        for (int i = 0; i < n; i++) begin
            w = 0;
            while (!pad_strb && w < 200) begin
                @(negedge clk);
                w++;
            end
            if (!pad_strb) begin
                chk("host_strb_wait", 0, 1);
                return;
            end
            rx_nib.push_back(pad_data);
            rx_last.push_back(pad_last);
            repeat (3) @(negedge clk);
            pad_ack = 1'b1;
            w = 0;
            while (pad_strb && w < 50) begin
                @(negedge clk);
                w++;
            end
            if (pad_strb) chk("host_strb_fall", 1, 0);
            pad_ack = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic check_word(input logic [63:0] d, input logic l,
                              input int base);
        logic [63:0] dv;
        dv = d;
        chk("rx_count", (rx_nib.size() >= base + 16), 1);
        if (rx_nib.size() < base + 16) return;
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("nib%0d", k), rx_nib[base+k], dv[63-4*k -: 4]);
            chk($sformatf("last%0d", k), rx_last[base+k], l && (k == 15));
        end
    endtask

    task automatic wait_ready();
        int w;
        w = 0;
        while (!s_ready && w < 10) begin
            @(negedge clk);
            w++;
        end
        chk("ready_back", s_ready, 1);
    endtask

    task automatic wait_strb();
        int w;
        w = 0;
        while (!pad_strb && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("strb_rise", pad_strb, 1);
    endtask

    initial begin
        int n;

        vecs[0] = '{64'h0123456789ABCDEF, 1'b0};
        vecs[1] = '{64'hFEDCBA9876543210, 1'b1};
        vecs[2] = '{64'hFFFFFFFFFFFFFFFF, 1'b0};
        vecs[3] = '{64'h0000000000000000, 1'b1};
        vecs[4] = '{64'hA5C3_0F96_5A3C_F069, 1'b1};

        rst_n   = 1'b0;
        s_valid = 1'b1;
        s_data  = 64'h1111_2222_3333_4444;
        s_last  = 1'b0;
        pad_ack = 1'b0;
        err_clr = 1'b0;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_ready", s_ready, 0);
            chk("rst_oeb", pad_oeb, 7'h7F);
            chk("rst_idle", pad_idle, 1);
            chk("rst_strb", pad_strb, 0);
            chk("rst_data", pad_data, 0);
            chk("rst_err", err, 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_oeb", pad_oeb, 7'h00);
        chk("post_rst_ready", s_ready, 1);
        chk("post_rst_last", pad_last, 0);
        s_valid = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            rx_nib.delete();
            rx_last.delete();
            fork
                send(vecs[v].data, vecs[v].last);
                recv(16);
            join
            check_word(vecs[v].data, vecs[v].last, 0);
            wait_ready();
        end

        // back-to-back words, second held valid while the first drains
        rx_nib.delete();
        rx_last.delete();
        fork
            begin
                send(64'h0123456789ABCDEF, 1'b0);
                send(64'hFEDCBA9876543210, 1'b1);
            end
            recv(32);
        join
        check_word(64'h0123456789ABCDEF, 1'b0, 0);
        check_word(64'hFEDCBA9876543210, 1'b1, 16);
        wait_ready();

        // stale ack held high across capture
        pad_ack = 1'b1;
        repeat (3) @(negedge clk);
        send(64'h13579BDF02468ACE, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("stale_strb", pad_strb, 0);
            chk("stale_busy", pad_idle, 0);
            @(negedge clk);
        end
        pad_ack = 1'b0;
        rx_nib.delete();
        rx_last.delete();
        recv(16);
        check_word(64'h13579BDF02468ACE, 1'b0, 0);
        wait_ready();

        // timeout in STRB with a silent host
        send(64'hDEADBEEFCAFEF00D, 1'b1);
        wait_strb();
        n = 0;
        while (pad_strb && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("to_strb_cycles", n, 16);
        chk("to_strb", pad_strb, 0);
        chk("to_err", err, 1);
        chk("to_ready", s_ready, 1);
        chk("to_data", pad_data, 0);
        chk("to_idle", pad_idle, 1);
        chk("to_last", pad_last, 0);
        repeat (2) @(negedge clk);
        chk("err_sticky", err, 1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("err_clr", err, 0);

        // clear coincident with the timeout edge
        send(64'h0F0F0F0F0F0F0F0F, 1'b0);
        wait_strb();
        repeat (15) @(negedge clk);
        chk("co_strb_still", pad_strb, 1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("co_err_set", err, 1);
        chk("co_strb", pad_strb, 0);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("co_err_clr", err, 0);

        // reset during nibble 7
        rx_nib.delete();
        rx_last.delete();
        fork
            send(64'h0123456789ABCDEF, 1'b0);
            recv(7);
        join
        wait_strb();
        chk("mid_nib7", pad_data, 4'h7);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_strb", pad_strb, 0);
        chk("mid_rst_data", pad_data, 0);
        chk("mid_rst_idle", pad_idle, 1);
        chk("mid_rst_oeb", pad_oeb, 7'h7F);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_post_oeb", pad_oeb, 7'h00);
        chk("mid_post_ready", s_ready, 1);
        rx_nib.delete();
        rx_last.delete();
        fork
            send(64'hFEDCBA9876543210, 1'b1);
            recv(16);
        join
        check_word(64'hFEDCBA9876543210, 1'b1, 0);
        wait_ready();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
